// File: rtl/mmio_led_pwm_ctrl.sv
// Multi-channel MMIO LED controller: static, PWM and blink modes per channel, frame-shadowed duty.
// Optional MMIO_LED_BREATHE_EN turns mode 11 into a triangle-ramp "breathe" mode (else mode 11 = off).
module mmio_led_pwm_ctrl #(
  parameter int unsigned     NUM_CH       = 4,
  parameter int unsigned     PWM_BITS     = 8,
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     ALEN         = 32,
  parameter logic [ALEN-1:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter logic [15:0]     PRESCALE_RST = 16'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_valid_i,
  input  logic              bus_we_i,
  input  logic [ALEN-1:0]   bus_addr_i,
  input  logic [XLEN-1:0]   bus_wdata_i,
  output logic [XLEN-1:0]   bus_rdata_o,
  output logic              bus_rvalid_o,
  output logic              bus_err_o,
  output logic [NUM_CH-1:0] led_o,
  output logic              frame_o
);

  localparam int unsigned         DutyBase = 4;
  localparam logic [5:0]          LastWord = 6'(DutyBase + NUM_CH - 1);
  localparam logic [PWM_BITS-1:0] PwmMax   = '1;

  // Register file
  logic [NUM_CH-1:0]   led_out_q;
  logic [2*NUM_CH-1:0] mode_q;
  logic [15:0]         prescale_q;
  logic [7:0]          blink_period_q;
  logic [PWM_BITS-1:0] shadow_q [NUM_CH];
  logic [PWM_BITS-1:0] active_q [NUM_CH];

  // Timing state
  logic [15:0]         pre_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [7:0]          frame_cnt_q;
  logic                blink_ph_q;

  // Registered outputs
  logic [NUM_CH-1:0]   led_q, led_d;
  logic                frame_q;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                rvalid_q;
  logic                err_q;

  logic              win_hit, mapped, rd_acc;
  logic [5:0]        word;
  logic              wr_led, wr_mode, wr_pre, wr_blink;
  logic [NUM_CH-1:0] wr_duty;
  logic              tick, wrap;
  logic [NUM_CH-1:0] breathe_on;
  logic              unused_bus;

  // Address decode; byte lanes [1:0] are not decoded
  assign win_hit  = bus_valid_i && (bus_addr_i[ALEN-1:8] == BASE_ADDR[ALEN-1:8]);
  assign word     = bus_addr_i[7:2];
  assign mapped   = (word <= LastWord);
  assign rd_acc   = win_hit && !bus_we_i;
  assign wr_led   = win_hit && bus_we_i && (word == 6'd0);
  assign wr_mode  = win_hit && bus_we_i && (word == 6'd1);
  assign wr_pre   = win_hit && bus_we_i && (word == 6'd2);
  assign wr_blink = win_hit && bus_we_i && (word == 6'd3);

  assign unused_bus = ^{bus_addr_i[1:0], bus_wdata_i};

  always_comb begin
    wr_duty = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_duty[i] = win_hit && bus_we_i && (word == 6'(DutyBase + i));
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_acc && mapped) begin
      case (word)
        6'd0:    rdata_d[NUM_CH-1:0]   = led_out_q;
        6'd1:    rdata_d[2*NUM_CH-1:0] = mode_q;
        6'd2:    rdata_d[15:0]         = prescale_q;
        6'd3:    rdata_d[7:0]          = blink_period_q;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (word == 6'(DutyBase + i)) rdata_d[PWM_BITS-1:0] = shadow_q[i];
          end
        end
      endcase
    end
  end

  // A PRESCALE write restarts the frame, so the wrap it would coincide with is dropped
  assign tick = (pre_cnt_q == prescale_q);
  assign wrap = tick && (pwm_cnt_q == PwmMax) && !wr_pre;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_out_q      <= '0;
      mode_q         <= '0;
      prescale_q     <= PRESCALE_RST;
      blink_period_q <= '0;
      rdata_q        <= '0;
      rvalid_q       <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      if (wr_led)   led_out_q      <= bus_wdata_i[NUM_CH-1:0];
      if (wr_mode)  mode_q         <= bus_wdata_i[2*NUM_CH-1:0];
      if (wr_pre)   prescale_q     <= bus_wdata_i[15:0];
      if (wr_blink) blink_period_q <= bus_wdata_i[7:0];
      rdata_q  <= rdata_d;
      rvalid_q <= rd_acc;
      err_q    <= win_hit && !mapped;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      frame_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      if (wr_pre) begin
        pre_cnt_q <= '0;
        pwm_cnt_q <= '0;
      end else if (tick) begin
        pre_cnt_q <= '0;
        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      end else begin
        pre_cnt_q <= pre_cnt_q + 16'd1;
      end
      if (wrap) begin
        if (frame_cnt_q == blink_period_q) begin
          frame_cnt_q <= '0;
          blink_ph_q  <= !blink_ph_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
      end
      frame_q <= wrap;
    end
  end

  // Duty shadow/active pair; a write landing on the wrap goes straight to active
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_duty[i]) shadow_q[i] <= bus_wdata_i[PWM_BITS-1:0];
        if (wrap) active_q[i] <= wr_duty[i] ? bus_wdata_i[PWM_BITS-1:0] : shadow_q[i];
      end
    end
  end

`ifdef MMIO_LED_BREATHE_EN
  logic [PWM_BITS-1:0] ramp_q [NUM_CH];
  logic [NUM_CH-1:0]   ramp_up_q;

  // Ramp restarts from 0 (rising) whenever a channel newly enters mode 11
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ramp_q[i] <= '0;
      ramp_up_q <= '1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_mode && (bus_wdata_i[2*i +: 2] == 2'b11) && (mode_q[2*i +: 2] != 2'b11)) begin
          ramp_q[i]    <= '0;
          ramp_up_q[i] <= 1'b1;
        end else if (wrap) begin
          if (ramp_up_q[i]) begin
            if (ramp_q[i] == PwmMax) begin
              ramp_q[i]    <= PwmMax - PWM_BITS'(1);
              ramp_up_q[i] <= 1'b0;
            end else begin
              ramp_q[i] <= ramp_q[i] + PWM_BITS'(1);
            end
          end else begin
            if (ramp_q[i] == '0) begin
              ramp_q[i]    <= PWM_BITS'(1);
              ramp_up_q[i] <= 1'b1;
            end else begin
              ramp_q[i] <= ramp_q[i] - PWM_BITS'(1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    breathe_on = '0;
    for (int i = 0; i < NUM_CH; i++) breathe_on[i] = (pwm_cnt_q < ramp_q[i]);
  end
`else
  assign breathe_on = '0;
`endif

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (mode_q[2*i +: 2])
        2'b00:   led_d[i] = led_out_q[i];
        2'b01:   led_d[i] = (pwm_cnt_q < active_q[i]);
        2'b10:   led_d[i] = blink_ph_q && (pwm_cnt_q < active_q[i]);
        default: led_d[i] = breathe_on[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= led_d;
  end

  assign bus_rdata_o  = rdata_q;
  assign bus_rvalid_o = rvalid_q;
  assign bus_err_o    = err_q;
  assign led_o        = led_q;
  assign frame_o      = frame_q;

endmodule

// File: tb/tb_mmio_led_pwm_ctrl.sv
// Self-checking bench for mmio_led_pwm_ctrl (NUM_CH=4, PWM_BITS=4); duty/blink checked by
// counting LED-high cycles per frame against duty*(PRESCALE+1).
module tb_mmio_led_pwm_ctrl;

  localparam int unsigned NCh    = 4;
  localparam int unsigned Pb     = 4;
  localparam logic [31:0] Base   = 32'hFFFF_FF00;
  localparam logic [15:0] PreRst = 16'd3;
  localparam int          Frame  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           bus_valid_i, bus_we_i;
  logic [31:0]    bus_addr_i, bus_wdata_i;
  logic [31:0]    bus_rdata_o;
  logic           bus_rvalid_o, bus_err_o;
  logic [NCh-1:0] led_o;
  logic           frame_o;

  int n_checks = 0;
  int n_fails  = 0;
  int hi_cnt [NCh];
  int fr_pulses, fr_last;

  mmio_led_pwm_ctrl #(
    .NUM_CH(NCh), .PWM_BITS(Pb), .XLEN(32), .ALEN(32), .BASE_ADDR(Base), .PRESCALE_RST(PreRst)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_valid_i(bus_valid_i), .bus_we_i(bus_we_i),
    .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .bus_rdata_o(bus_rdata_o),
    .bus_rvalid_o(bus_rvalid_o), .bus_err_o(bus_err_o), .led_o(led_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output logic er);
    bus_valid_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = addr; bus_wdata_i = data;
    cyc();
    bus_valid_i = 1'b0; bus_we_i = 1'b0;
    er = bus_err_o;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic rv,
                          output logic er);
    bus_valid_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = addr;
    cyc();
    bus_valid_i = 1'b0;
    data = bus_rdata_o; rv = bus_rvalid_o; er = bus_err_o;
  endtask

  // Returns positioned on the cycle where frame_o is high
  task automatic wait_frame();
    bit ok = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      cyc();
      if (frame_o) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL frame_timeout: got no frame_o, required a pulse"); end
  endtask

  task automatic measure_frame(input int len);
    for (int c = 0; c < NCh; c++) hi_cnt[c] = 0;
    fr_pulses = 0; fr_last = -1;
    for (int k = 0; k < len; k++) begin
      cyc();
      for (int c = 0; c < NCh; c++) if (led_o[c]) hi_cnt[c]++;
      if (frame_o) begin fr_pulses++; fr_last = k; end
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    case (w)
      0:       return 32'((1 << NCh) - 1);
      1:       return 32'((1 << (2 * NCh)) - 1);
      2:       return 32'h0000_FFFF;
      3:       return 32'h0000_00FF;
      default: return (w < 4 + NCh) ? 32'((1 << Pb) - 1) : 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] d, expv;
    logic rv, er;
    rst_n = 1'b0;
    bus_valid_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = Base; bus_wdata_i = 32'hFFFF_FFFF;
    repeat (3) cyc();
    n_checks++;
    if ({bus_rvalid_o, bus_err_o, frame_o, led_o} !== '0) begin
      n_fails++;
      $display("FAIL reset_outputs: got %0h required 0", {bus_rvalid_o, bus_err_o, frame_o, led_o});
    end
    bus_valid_i = 1'b0; bus_we_i = 1'b0; rst_n = 1'b1;
    cyc();
    for (int w = 0; w < 4 + NCh; w++) begin
      expv = (w == 2) ? 32'(PreRst) : 32'h0;
      bus_read(Base + 32'(w * 4), d, rv, er);
      n_checks++;
      if (d !== expv || rv !== 1'b1 || er !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_reg%0d: got data=%0h rv=%b err=%b required data=%0h rv=1 err=0",
                 w, d, rv, er, expv);
      end
    end
  endtask

  task automatic test_pwm_basic();
    logic er;
    bus_write(Base + 32'h08, 32'd0, er);
    bus_write(Base + 32'h04, 32'h1, er);
    bus_write(Base + 32'h10, 32'd4, er);
    wait_frame();
    for (int f = 0; f < 2; f++) begin
      measure_frame(Frame);
      n_checks++;
      if (hi_cnt[0] != 4) begin
        n_fails++; $display("FAIL pwm_duty4: got %0d high cycles required 4", hi_cnt[0]);
      end
      n_checks++;
      if (fr_pulses != 1 || fr_last != Frame - 1) begin
        n_fails++;
        $display("FAIL frame_period: got %0d pulses last at %0d required 1 at %0d",
                 fr_pulses, fr_last, Frame - 1);
      end
    end
  endtask

  task automatic test_shadow();
    logic [31:0] d;
    logic rv, er;
    int h = 0;
    for (int k = 0; k < Frame; k++) begin
      if (k == 5) begin
        bus_valid_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = Base + 32'h10; bus_wdata_i = 32'd12;
      end
      cyc();
      if (k == 5) begin bus_valid_i = 1'b0; bus_we_i = 1'b0; end
      if (led_o[0]) h++;
    end
    n_checks++;
    if (h != 4) begin n_fails++; $display("FAIL shadow_hold: got %0d required 4", h); end
    measure_frame(Frame);
    n_checks++;
    if (hi_cnt[0] != 12) begin
      n_fails++; $display("FAIL shadow_apply: got %0d required 12", hi_cnt[0]);
    end
    bus_read(Base + 32'h10, d, rv, er);
    n_checks++;
    if (d !== 32'd12) begin n_fails++; $display("FAIL duty_readback: got %0h required c", d); end
    wait_frame();
    repeat (15) cyc();
    // this write lands in the wrap cycle
    bus_write(Base + 32'h10, 32'd7, er);
    n_checks++;
    if (frame_o !== 1'b1) begin
      n_fails++; $display("FAIL coincident_align: got frame_o=%b required 1", frame_o);
    end
    measure_frame(Frame);
    n_checks++;
    if (hi_cnt[0] != 7) begin
      n_fails++; $display("FAIL coincident_duty: got %0d required 7", hi_cnt[0]);
    end
  endtask

  task automatic test_blink();
    logic er;
    int c [8];
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    bus_write(Base + 32'h04, 32'h8, er);
    bus_write(Base + 32'h14, 32'd15, er);
    bus_write(Base + 32'h0C, 32'd1, er);
    bus_write(Base + 32'h08, 32'd2, er);
    wait_frame();
    for (int f = 0; f < 8; f++) begin
      measure_frame(Frame * 3);
      c[f] = hi_cnt[1];
      n_checks++;
      if (fr_pulses != 1 || fr_last != Frame * 3 - 1 || (c[f] != 0 && c[f] != 45)) begin
        n_fails++;
        $display("FAIL blink_frame%0d: got pulses=%0d last=%0d high=%0d required 1/47/(0|45)",
                 f, fr_pulses, fr_last, c[f]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (c[k] == c[k + 2]) begin
        n_fails++;
        $display("FAIL blink_phase%0d: got %0d and %0d two frames apart, required different",
                 k, c[k], c[k + 2]);
      end
    end
  endtask

  task automatic test_window();
    logic [31:0] d;
    logic rv, er;
    bus_write(Base, 32'h5, er);
    n_checks++;
    if (er !== 1'b0) begin n_fails++; $display("FAIL led_write_err: got %b required 0", er); end
    bus_read(Base + 32'h50, d, rv, er);
    n_checks++;
    if (rv !== 1'b1 || er !== 1'b1 || d !== 32'h0) begin
      n_fails++; $display("FAIL unmapped_read: got rv=%b err=%b d=%0h required 1 1 0", rv, er, d);
    end
    cyc();
    n_checks++;
    if (bus_rvalid_o !== 1'b0 || bus_err_o !== 1'b0) begin
      n_fails++;
      $display("FAIL pulse_width: got rv=%b err=%b required 0 0", bus_rvalid_o, bus_err_o);
    end
    bus_write(Base + 32'h50, 32'hFFFF_FFFF, er);
    n_checks++;
    if (er !== 1'b1) begin n_fails++; $display("FAIL unmapped_write_err: got %b required 1", er); end
    bus_read(Base + 32'hFC, d, rv, er);
    n_checks++;
    if (rv !== 1'b1 || er !== 1'b1 || d !== 32'h0) begin
      n_fails++; $display("FAIL offset_fc: got rv=%b err=%b d=%0h required 1 1 0", rv, er, d);
    end
    bus_read(Base + 32'h100, d, rv, er);
    n_checks++;
    if (rv !== 1'b0 || er !== 1'b0) begin
      n_fails++; $display("FAIL outside_read: got rv=%b err=%b required 0 0", rv, er);
    end
    bus_write(Base + 32'h100, 32'hFFFF_FFFF, er);
    n_checks++;
    if (er !== 1'b0) begin n_fails++; $display("FAIL outside_write_err: got %b required 0", er); end
    bus_read(Base, d, rv, er);
    n_checks++;
    if (d !== 32'h5) begin n_fails++; $display("FAIL led_preserved: got %0h required 5", d); end
  endtask

  task automatic test_random_regs();
    logic [31:0] expv [64];
    logic [31:0] d, data;
    logic rv, er;
    int w;
    bit mp;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    for (int i = 0; i < 64; i++) expv[i] = 32'h0;
    expv[2] = 32'(PreRst);
    repeat (48) begin
      w = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
      mp = (w < 4 + NCh);
      data = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        bus_write(Base + 32'(w * 4), data, er);
        if (mp) expv[w] = data & mask_of(w);
        n_checks++;
        if (er !== !mp) begin
          n_fails++; $display("FAIL rand_write_err w%0d: got %b required %b", w, er, !mp);
        end
      end else begin
        bus_read(Base + 32'(w * 4), d, rv, er);
        n_checks++;
        if (d !== expv[w] || rv !== 1'b1 || er !== !mp) begin
          n_fails++;
          $display("FAIL rand_read w%0d: got d=%0h rv=%b err=%b required d=%0h rv=1 err=%b",
                   w, d, rv, er, expv[w], !mp);
        end
      end
    end
  endtask

  task automatic test_random_pwm();
    logic er;
    int p;
    int duty [NCh];
    bus_write(Base + 32'h04, 32'h55, er);
    for (int it = 0; it < 4; it++) begin
      p = int'($urandom_range(0, 3));
      for (int c = 0; c < NCh; c++) begin
        duty[c] = int'($urandom_range(0, 15));
        bus_write(Base + 32'h10 + 32'(c * 4), 32'(duty[c]), er);
      end
      bus_write(Base + 32'h08, 32'(p), er);
      wait_frame();
      measure_frame(Frame * (p + 1));
      for (int c = 0; c < NCh; c++) begin
        n_checks++;
        if (hi_cnt[c] != duty[c] * (p + 1)) begin
          n_fails++;
          $display("FAIL rand_pwm it%0d ch%0d: got %0d required %0d (duty %0d prescale %0d)",
                   it, c, hi_cnt[c], duty[c] * (p + 1), duty[c], p);
        end
      end
    end
  endtask

  task automatic test_static_mode3();
    logic er;
    logic [NCh-1:0] v;
    bus_write(Base + 32'h04, 32'h0, er);
    for (int it = 0; it < 3; it++) begin
      v = NCh'($urandom);
      bus_write(Base, 32'(v), er);
      cyc(); cyc();
      n_checks++;
      if (led_o !== v) begin n_fails++; $display("FAIL static it%0d: got %0h required %0h", it, led_o, v); end
    end
    bus_write(Base + 32'h08, 32'd0, er);
`ifdef MMIO_LED_BREATHE_EN
    begin
      int r = 1;
      bit up = 1'b1;
      bus_write(Base + 32'h04, 32'h30, er);
      wait_frame();
      for (int f = 0; f < 34; f++) begin
        measure_frame(Frame);
        n_checks++;
        if (hi_cnt[2] != r) begin
          n_fails++; $display("FAIL breathe f%0d: got %0d required %0d", f, hi_cnt[2], r);
        end
        if (up) begin
          if (r == 15) begin r = 14; up = 1'b0; end else r++;
        end else begin
          if (r == 0) begin r = 1; up = 1'b1; end else r--;
        end
      end
    end
`else
    bus_write(Base + 32'h10, 32'd15, er);
    bus_write(Base + 32'h18, 32'd15, er);
    bus_write(Base + 32'h04, 32'h31, er);
    wait_frame();
    measure_frame(Frame);
    n_checks++;
    if (hi_cnt[2] != 0 || hi_cnt[0] != 15) begin
      n_fails++;
      $display("FAIL mode3_off: got ch2=%0d ch0=%0d required 0 15", hi_cnt[2], hi_cnt[0]);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    bus_valid_i = 1'b0; bus_we_i = 1'b0; bus_addr_i = '0; bus_wdata_i = '0;
    test_reset();
    test_pwm_basic();
    test_shadow();
    test_blink();
    test_window();
    test_random_regs();
    test_random_pwm();
    test_static_mode3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
